// File: rtl/mhp_pkg.sv
// rtl/mhp_pkg.sv - shared MHP frame constants, header offsets and parser state encoding
// Purpose: common definitions for frame_assembly / frame_parser.
// Ports: none (package).
package mhp_pkg;

  localparam int HDR_BYTES     = 7;
  localparam int PAYLOAD_BYTES = 42;

  // Big-endian header byte offsets.
  localparam int DST_OFS  = 0;
  localparam int SRC_OFS  = 2;
  localparam int SIZE_OFS = 4;
  localparam int CTRL_OFS = 6;

  localparam logic [6:0] TYPE_PING = 7'h3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_PAY,
    ST_DONE,
    ST_WAIT
  } state_e;

endpackage

// File: rtl/frame_parser.sv
// rtl/frame_parser.sv - drains one MHP frame from the RX FIFO and presents decoded fields
// Purpose: read header + payload bytes, unpack dst/src/size/dir/type/payload,
//          hold them with o_valid until i_ack.
// Ports:
//   i_clk, i_rst        clock, async active-high reset
//   i_rdata, i_rready   RX FIFO byte (valid cycle after o_rreq) and not-empty flag
//   o_rreq              registered one-byte read request
//   o_dst/o_src/o_size  header fields
//   o_dir/o_type        control byte split
//   o_payload           payload, byte 0 in the top byte lane
//   o_valid, i_ack      frame handshake
//   o_err               one-cycle pulse when size exceeds payload capacity
module frame_parser #(
  parameter int PAYLOAD_BYTES = mhp_pkg::PAYLOAD_BYTES
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [7:0]                 i_rdata,
  input  logic                       i_rready,
  output logic                       o_rreq,
  output logic [15:0]                o_dst,
  output logic [15:0]                o_src,
  output logic [15:0]                o_size,
  output logic                       o_dir,
  output logic [6:0]                 o_type,
  output logic [8*PAYLOAD_BYTES-1:0] o_payload,
  output logic                       o_valid,
  input  logic                       i_ack,
  output logic                       o_err
);
  import mhp_pkg::ST_IDLE;
  import mhp_pkg::ST_HDR;
  import mhp_pkg::ST_PAY;
  import mhp_pkg::ST_DONE;
  import mhp_pkg::ST_WAIT;
  import mhp_pkg::state_e;
  import mhp_pkg::HDR_BYTES;
  import mhp_pkg::DST_OFS;
  import mhp_pkg::SRC_OFS;
  import mhp_pkg::SIZE_OFS;
  import mhp_pkg::CTRL_OFS;

  localparam int PW = 8 * PAYLOAD_BYTES;

  state_e          state_q, state_d;
  logic            rreq_q, rreq_d;
  logic            rd_pend_q, rd_pend_d;
  logic [16:0]     req_cnt_q, req_cnt_d;
  logic [16:0]     rx_cnt_q, rx_cnt_d;
  logic [15:0]     dst_q, dst_d;
  logic [15:0]     src_q, src_d;
  logic [15:0]     size_q, size_d;
  logic [7:0]      ctrl_q, ctrl_d;
  logic [PW-1:0]   payload_q, payload_d;
  logic            valid_q, valid_d;
  logic            err_q, err_d;

  logic [16:0]     full_len;
  logic [16:0]     req_limit;
  logic [16:0]     pay_idx;
  logic [16:0]     lane;
  logic [PW-1:0]   byte_ext;

  // Size is only trustworthy once bytes 4 and 5 are in (rx_cnt >= 6); before
  // that the request limit is the fixed header length.
  assign full_len  = 17'(HDR_BYTES) + {1'b0, size_q};
  assign req_limit = (rx_cnt_q > 17'd5) ? full_len : 17'(HDR_BYTES);
  assign pay_idx   = rx_cnt_q - 17'(HDR_BYTES);
  assign lane      = 17'(PAYLOAD_BYTES - 1) - pay_idx;
  assign byte_ext  = PW'(i_rdata);

  always_comb begin
    state_d   = state_q;
    rreq_d    = 1'b0;
    rd_pend_d = rreq_q;
    req_cnt_d = req_cnt_q;
    rx_cnt_d  = rx_cnt_q;
    dst_d     = dst_q;
    src_d     = src_q;
    size_d    = size_q;
    ctrl_d    = ctrl_q;
    payload_d = payload_q;
    valid_d   = valid_q;
    err_d     = 1'b0;

    if ((state_q == ST_HDR || state_q == ST_PAY) && i_rready && (req_cnt_q < req_limit)) begin
      rreq_d    = 1'b1;
      req_cnt_d = req_cnt_q + 17'd1;
    end

    case (state_q)
      ST_IDLE: begin
        payload_d = '0;
        req_cnt_d = '0;
        rx_cnt_d  = '0;
        if (i_rready && !valid_q) state_d = ST_HDR;
      end
      ST_HDR: begin
        if (rd_pend_q) begin
          rx_cnt_d = rx_cnt_q + 17'd1;
          case (rx_cnt_q)
            17'(DST_OFS):      dst_d[15:8]  = i_rdata;
            17'(DST_OFS + 1):  dst_d[7:0]   = i_rdata;
            17'(SRC_OFS):      src_d[15:8]  = i_rdata;
            17'(SRC_OFS + 1):  src_d[7:0]   = i_rdata;
            17'(SIZE_OFS):     size_d[15:8] = i_rdata;
            17'(SIZE_OFS + 1): size_d[7:0]  = i_rdata;
            17'(CTRL_OFS): begin
              ctrl_d  = i_rdata;
              state_d = (size_q == 16'd0) ? ST_DONE : ST_PAY;
            end
            default: ;
          endcase
        end
      end
      ST_PAY: begin
        if (rd_pend_q) begin
          rx_cnt_d = rx_cnt_q + 17'd1;
          // Payload was zeroed in IDLE, so OR-ing the byte into its lane is enough.
          if (pay_idx < 17'(PAYLOAD_BYTES)) payload_d = payload_q | (byte_ext << {lane, 3'b000});
          if (rx_cnt_q + 17'd1 == full_len) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        valid_d = 1'b1;
        err_d   = (size_q > 16'(PAYLOAD_BYTES));
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (i_ack) begin
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      rreq_q    <= 1'b0;
      rd_pend_q <= 1'b0;
      req_cnt_q <= '0;
      rx_cnt_q  <= '0;
      dst_q     <= '0;
      src_q     <= '0;
      size_q    <= '0;
      ctrl_q    <= '0;
      payload_q <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rreq_q    <= rreq_d;
      rd_pend_q <= rd_pend_d;
      req_cnt_q <= req_cnt_d;
      rx_cnt_q  <= rx_cnt_d;
      dst_q     <= dst_d;
      src_q     <= src_d;
      size_q    <= size_d;
      ctrl_q    <= ctrl_d;
      payload_q <= payload_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
    end
  end

  assign o_rreq    = rreq_q;
  assign o_dst     = dst_q;
  assign o_src     = src_q;
  assign o_size    = size_q;
  assign o_dir     = ctrl_q[7];
  assign o_type    = ctrl_q[6:0];
  assign o_payload = payload_q;
  assign o_valid   = valid_q;
  assign o_err     = err_q;

endmodule

// File: tb/tb_frame_parser.sv
// tb/tb_frame_parser.sv - self-checking bench for frame_parser
module tb_frame_parser;
  import mhp_pkg::*;

  localparam int PB = 42;
  localparam int PW = 8 * PB;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    rdata;
  logic          rready;
  logic          rreq;
  logic [15:0]   dst, src, size;
  logic          dir;
  logic [6:0]    typ;
  logic [PW-1:0] payload;
  logic          valid;
  logic          ack;
  logic          err;

  always #5 clk = ~clk;

  frame_parser #(.PAYLOAD_BYTES(PB)) dut (
    .i_clk(clk), .i_rst(rst), .i_rdata(rdata), .i_rready(rready), .o_rreq(rreq),
    .o_dst(dst), .o_src(src), .o_size(size), .o_dir(dir), .o_type(typ),
    .o_payload(payload), .o_valid(valid), .i_ack(ack), .o_err(err)
  );

  int checks = 0;
  int failures = 0;

  // RX FIFO model and per-frame observation counters
  logic [7:0] fifo[$];
  bit         prev_rreq = 0;
  bit         toggle = 0;
  int         gate_mode = 0;
  int         req_seen = 0, err_seen = 0, err_bad = 0, underflow = 0;

  task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One clock: at the falling edge, deliver the byte requested last cycle,
  // record observations, then present i_rready for the coming edge.
  task automatic cycle();
    bit g;
    @(negedge clk);
    if (prev_rreq) begin
      if (fifo.size() > 0) rdata = fifo.pop_front();
      else begin underflow++; rdata = 8'h00; end
    end
    prev_rreq = rreq;
    if (rreq) req_seen++;
    if (err) begin err_seen++; if (!valid) err_bad++; end
    case (gate_mode)
      1: begin g = toggle; toggle = ~toggle; end
      2: g = 1'($urandom_range(0, 1));
      default: g = 1'b1;
    endcase
    // Bytes not yet requested remain available
    rready = g && (fifo.size() > (rreq ? 1 : 0));
  endtask

  task automatic clear_obs();
    req_seen = 0; err_seen = 0; err_bad = 0; underflow = 0;
  endtask

  // Reference model: serialise a frame into the FIFO and compute expected payload.
  task automatic make_frame(input logic [15:0] d, input logic [15:0] s, input logic [15:0] sz,
                            input logic [7:0] c, input int pat, output logic [PW-1:0] pay);
    pay = '0;
    fifo.push_back(d[15:8]);  fifo.push_back(d[7:0]);
    fifo.push_back(s[15:8]);  fifo.push_back(s[7:0]);
    fifo.push_back(sz[15:8]); fifo.push_back(sz[7:0]);
    fifo.push_back(c);
    for (int i = 0; i < int'(sz); i++) begin
      logic [7:0] b;
      b = (pat == 0) ? 8'hAA + 8'(i * 17) : 8'($urandom);
      fifo.push_back(b);
      if (i < PB) pay[8*(PB-1-i) +: 8] = b;
    end
  endtask

  task automatic wait_valid(input string tag);
    bit ok = 0;
    for (int n = 0; n < 3000 && !ok; n++) begin
      cycle();
      if (valid) ok = 1;
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s_timeout actual=no_valid required=valid", tag);
    end
  endtask

  task automatic check_frame(input string tag, input logic [15:0] d, input logic [15:0] s,
                             input logic [15:0] sz, input logic [7:0] c,
                             input logic [PW-1:0] pay, input int exp_reqs, input int exp_err);
    chk({tag, "_dst"}, dst, d);
    chk({tag, "_src"}, src, s);
    chk({tag, "_size"}, size, sz);
    chk({tag, "_dir"}, dir, c[7]);
    chk({tag, "_type"}, typ, c[6:0]);
    chk({tag, "_payload"}, payload, pay);
    chk({tag, "_reqs"}, req_seen, exp_reqs);
    chk({tag, "_err"}, err_seen, exp_err);
    chk({tag, "_err_align"}, err_bad, 0);
    chk({tag, "_underflow"}, underflow, 0);
  endtask

  // Hold off the ack, confirm nothing moves, then ack and confirm o_valid drops.
  task automatic hold_and_ack(input string tag, input int hold, input logic [15:0] d,
                              input logic [15:0] s, input logic [15:0] sz, input logic [PW-1:0] pay);
    int bad = 0;
    for (int n = 0; n < hold; n++) begin
      cycle();
      if (rreq !== 1'b0 || valid !== 1'b1 || dst !== d || src !== s || size !== sz || payload !== pay) bad++;
    end
    chk({tag, "_hold_stable"}, bad, 0);
    ack = 1'b1;
    cycle();
    ack = 1'b0;
    chk({tag, "_valid_clear"}, valid, 1'b0);
    clear_obs();
  endtask

  typedef struct {
    logic [15:0] d;
    logic [15:0] s;
    logic [15:0] sz;
    logic [7:0]  c;
    int          pat;
    int          gate;
    int          hold;
    int          exp_reqs;
    int          exp_err;
  } vec_t;

  vec_t          tbl[7];
  logic [PW-1:0] pay_a, pay_b, exp_pay;
  logic [15:0]   rd, rs, rsz;
  logic [7:0]    rc;
  int            cnt;

  initial begin
    tbl[0] = '{16'hFFFF, 16'h0000, 16'd0,  {1'b1, TYPE_PING}, 0, 0, 2, 7,  0};
    tbl[1] = '{16'h1234, 16'h5678, 16'd3,  8'h05,             0, 0, 3, 10, 0};
    tbl[2] = '{16'h0001, 16'h0002, 16'd42, 8'h7F,             1, 1, 1, 49, 0};
    tbl[3] = '{16'hABCD, 16'h0102, 16'd50, 8'h83,             1, 0, 0, 57, 1};
    tbl[4] = '{16'h0F0F, 16'hF0F0, 16'd41, 8'h11,             1, 2, 4, 48, 0};
    tbl[5] = '{16'h8000, 16'h0001, 16'd43, 8'hC2,             1, 2, 1, 50, 1};
    tbl[6] = '{16'h5A5A, 16'hA5A5, 16'd1,  8'h00,             0, 1, 2, 8,  0};

    rst = 1'b1; ack = 1'b0; rready = 1'b0; rdata = 8'h00;
    cycle(); cycle(); cycle();
    chk("reset_rreq", rreq, 1'b0);
    chk("reset_valid", valid, 1'b0);
    chk("reset_err", err, 1'b0);
    chk("reset_fields", {dst, src, size, dir, typ}, '0);
    chk("reset_payload", payload, '0);
    rst = 1'b0;
    cycle();
    clear_obs();

    // An ack with nothing pending must be ignored
    ack = 1'b1; cycle(); ack = 1'b0; cycle();
    chk("idle_ack_valid", valid, 1'b0);

    for (int v = 0; v < 7; v++) begin
      gate_mode = tbl[v].gate;
      clear_obs();
      make_frame(tbl[v].d, tbl[v].s, tbl[v].sz, tbl[v].c, tbl[v].pat, exp_pay);
      wait_valid($sformatf("vec%0d", v));
      check_frame($sformatf("vec%0d", v), tbl[v].d, tbl[v].s, tbl[v].sz, tbl[v].c,
                  exp_pay, tbl[v].exp_reqs, tbl[v].exp_err);
      hold_and_ack($sformatf("vec%0d", v), tbl[v].hold, tbl[v].d, tbl[v].s, tbl[v].sz, exp_pay);
    end

    // Second frame queued behind an unacknowledged first one
    gate_mode = 0;
    clear_obs();
    make_frame(16'h1111, 16'h2222, 16'd5, 8'h03, 1, pay_a);
    make_frame(16'h3333, 16'h4444, 16'd2, 8'h84, 1, pay_b);
    wait_valid("queued_a");
    check_frame("queued_a", 16'h1111, 16'h2222, 16'd5, 8'h03, pay_a, 12, 0);
    hold_and_ack("queued_a", 20, 16'h1111, 16'h2222, 16'd5, pay_a);
    wait_valid("queued_b");
    check_frame("queued_b", 16'h3333, 16'h4444, 16'd2, 8'h84, pay_b, 9, 0);
    hold_and_ack("queued_b", 1, 16'h3333, 16'h4444, 16'd2, pay_b);

    // Reset in the middle of a frame, after byte 3 has been captured
    clear_obs();
    make_frame(16'hDEAD, 16'hBEEF, 16'd10, 8'h01, 1, pay_a);
    cnt = 0;
    while (req_seen < 5 && cnt < 100) begin cycle(); cnt++; end
    cycle(); cycle();
    #2 rst = 1'b1;
    #1;
    chk("midrst_rreq", rreq, 1'b0);
    chk("midrst_valid", valid, 1'b0);
    chk("midrst_fields", {dst, src, size, dir, typ}, '0);
    chk("midrst_payload", payload, '0);
    fifo.delete();
    prev_rreq = 0;
    cycle(); cycle();
    rst = 1'b0;
    cycle(); cycle(); cycle();
    chk("midrst_no_valid", valid, 1'b0);
    clear_obs();
    make_frame(16'h0A0B, 16'h0C0D, 16'd4, 8'h83, 0, pay_a);
    wait_valid("post_rst");
    check_frame("post_rst", 16'h0A0B, 16'h0C0D, 16'd4, 8'h83, pay_a, 11, 0);
    hold_and_ack("post_rst", 1, 16'h0A0B, 16'h0C0D, 16'd4, pay_a);

    // Randomized frames against the model
    for (int r = 0; r < 20; r++) begin
      rd  = 16'($urandom);
      rs  = 16'($urandom);
      rsz = 16'($urandom_range(0, 60));
      rc  = 8'($urandom);
      gate_mode = $urandom_range(0, 2);
      clear_obs();
      make_frame(rd, rs, rsz, rc, 1, exp_pay);
      wait_valid($sformatf("rnd%0d", r));
      check_frame($sformatf("rnd%0d", r), rd, rs, rsz, rc, exp_pay,
                  7 + int'(rsz), (int'(rsz) > PB) ? 1 : 0);
      hold_and_ack($sformatf("rnd%0d", r), $urandom_range(0, 5), rd, rs, rsz, exp_pay);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
